prog_loader: RTL and testbench

- Program-mode RAM writer. It is the write-side counterpart of the control unit's fetch/read sequencing.
- While run=0, it accepts bytes over a valid/ready handshake (switch panel or UART receiver) and writes them into the 16x8 program RAM. It sequences address, data, CS and nWE with a setup/strobe/hold pattern.
- While run=1, it releases nWE, CS and the data bus to hi-Z so the control unit owns RAM.

---
 rtl/prog_loader.sv | 142 ++++++++++++++
 tb/tb_prog_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program-mode RAM writer: takes bytes over valid/ready and writes them into the
// program RAM using a setup/strobe/hold cycle. It releases the RAM pins in run mode.
module prog_loader #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              CLK,
  input  logic              nCLR,
  input  logic              run,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  inout  wire               nWE,
  inout  wire               CS,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count
);

  localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC) ?
                           ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                           ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                done_reg, done_next;
  logic [ADDR_W:0]     count_reg, count_next;
  logic                stage_last;
  logic                cs_int, nwe_int;

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    stage_last = 1'b0;
    case (state_reg)
      SETUP:   stage_last = (cnt_reg == CNT_W'(SETUP_CYC - 1));
      STROBE:  stage_last = (cnt_reg == CNT_W'(PULSE_CYC - 1));
      HOLD:    stage_last = (cnt_reg == CNT_W'(HOLD_CYC - 1));
      default: stage_last = 1'b0;
    endcase
  end

  assign in_ready = (state_reg == IDLE) && !run && !done_reg && !addr_load;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    done_next  = done_reg;
    count_next = count_reg;
    if (state_reg != IDLE && run) begin
      // Run mode steals the RAM mid-cycle: drop the byte, keep pointer and count.
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (addr_load) begin
            addr_next  = addr_in;
            done_next  = 1'b0;
            count_next = '0;
          end else if (in_valid && in_ready) begin
            data_next  = in_data;
            state_next = SETUP;
            cnt_next   = '0;
          end
        end
        SETUP: begin
          cnt_next = cnt_reg + 1'b1;
          if (stage_last) begin
            state_next = STROBE;
            cnt_next   = '0;
          end
        end
        STROBE: begin
          cnt_next = cnt_reg + 1'b1;
          if (stage_last) begin
            state_next = HOLD;
            cnt_next   = '0;
          end
        end
        HOLD: begin
          cnt_next = cnt_reg + 1'b1;
          if (stage_last) begin
            state_next = IDLE;
            cnt_next   = '0;
            addr_next  = addr_reg + 1'b1;
            count_next = count_reg + 1'b1;
            if (addr_reg == {ADDR_W{1'b1}}) done_next = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign cs_int  = (state_reg != IDLE);
  assign nwe_int = (state_reg != STROBE);

  // Pins float the moment run rises, independent of the FSM.
  assign CS       = run ? 1'bz : cs_int;
  assign nWE      = run ? 1'bz : nwe_int;
  assign ram_data = (!run && cs_int) ? data_reg : {DATA_W{1'bz}};

  assign ram_addr = addr_reg;
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign wr_count = count_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a negedge monitor models the RAM from the pins,
// and each scenario task checks its own expected values inline.
module tb_prog_loader;

  logic       CLK = 1'b0;
  logic       nCLR = 1'b0;
  logic       run = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       addr_load = 1'b0;
  logic [3:0] addr_in = 4'h0;
  logic       in_ready;
  logic [3:0] ram_addr;
  logic       busy;
  logic       done;
  logic [4:0] wr_count;
  wire  [7:0] ram_data;
  wire        nWE;
  wire        CS;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  // Released pins read back opposite to their strobe levels.
  pullup   (nWE);
  pulldown (CS);
  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_pd
    pulldown (ram_data[gi]);
  end

  prog_loader dut (
    .CLK(CLK), .nCLR(nCLR), .run(run), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .addr_load(addr_load), .addr_in(addr_in),
    .ram_addr(ram_addr), .ram_data(ram_data), .nWE(nWE), .CS(CS),
    .busy(busy), .done(done), .wr_count(wr_count)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // RAM model: a write commits when the strobe ends with the loader still owning the bus.
  logic [7:0] mem [16];
  int         nwrites = 0;
  int         pulse_log [32];
  int         glitches = 0;
  logic       in_strobe = 1'b0;
  int         plen = 0;
  logic [3:0] s_addr = 4'h0;
  logic [7:0] s_data = 8'h00;

  always @(negedge CLK) begin
    if (nCLR && !run && CS === 1'b1 && nWE === 1'b0) begin
      if (!in_strobe) begin
        in_strobe <= 1'b1;
        plen      <= 1;
        s_addr    <= ram_addr;
        s_data    <= ram_data;
      end else begin
        plen <= plen + 1;
        if (ram_addr !== s_addr || ram_data !== s_data) glitches <= glitches + 1;
      end
    end else if (in_strobe) begin
      in_strobe <= 1'b0;
      if (!run) begin
        mem[s_addr] <= s_data;
        if (nwrites < 32) pulse_log[nwrites] <= plen;
        nwrites <= nwrites + 1;
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout busy=%b required 0", tag, busy);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    #1;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready_timeout byte=%h in_ready=%b required 1", b, in_ready);
    end
    $display("tx byte %h at addr %h cycle %0d", b, ram_addr, cyc);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    tick();
    tick();
    vectors++; if (ram_addr !== 4'h0) begin errors++; $display("FAIL rst_addr got=%h required 0", ram_addr); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b required 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b required 0", done); end
    vectors++; if (wr_count !== 5'd0) begin errors++; $display("FAIL rst_count got=%0d required 0", wr_count); end
    vectors++; if (CS !== 1'b0 || nWE !== 1'b1) begin errors++; $display("FAIL rst_pins CS=%b nWE=%b required 0/1", CS, nWE); end
    nCLR = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b required 1", in_ready); end
    $display("reset released cycle %0d", cyc);
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    logic [2:0] pat [5];
    int         acc [3];
    int         n;
    bytes = '{8'h1E, 8'h2F, 8'hE0};
    pat   = '{3'b111, 3'b101, 3'b101, 3'b111, 3'b010};  // {CS, nWE, busy}
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = bytes[i];
      #1;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      vectors++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_timeout byte=%0d in_ready=%b", i, in_ready); end
      acc[i] = cyc;
      $display("tx byte %h at addr %h cycle %0d", bytes[i], ram_addr, cyc);
      tick();
      if (i == 0) begin
        for (int k = 0; k < 5; k++) begin
          vectors++;
          if ({CS, nWE, busy} !== pat[k]) begin
            errors++;
            $display("FAIL b2b_pattern step=%0d got=%b required %b", k, {CS, nWE, busy}, pat[k]);
          end
          if (k < 4) begin
            vectors++;
            if (ram_data !== 8'h1E || ram_addr !== 4'h0) begin
              errors++;
              $display("FAIL b2b_bus step=%0d data=%h addr=%h required 1e/0", k, ram_data, ram_addr);
            end
            tick();
          end
        end
      end
    end
    in_valid = 1'b0;
    wait_idle("b2b");
    vectors++; if (acc[1] - acc[0] !== 5 || acc[2] - acc[1] !== 5) begin errors++; $display("FAIL b2b_spacing got=%0d,%0d required 5,5", acc[1] - acc[0], acc[2] - acc[1]); end
    vectors++; if (mem[0] !== 8'h1E || mem[1] !== 8'h2F || mem[2] !== 8'hE0) begin errors++; $display("FAIL b2b_mem got=%h %h %h required 1e 2f e0", mem[0], mem[1], mem[2]); end
    vectors++; if (pulse_log[0] !== 2 || pulse_log[1] !== 2 || pulse_log[2] !== 2) begin errors++; $display("FAIL b2b_pulse got=%0d %0d %0d required 2", pulse_log[0], pulse_log[1], pulse_log[2]); end
    vectors++; if (wr_count !== 5'd3 || ram_addr !== 4'h3) begin errors++; $display("FAIL b2b_count cnt=%0d addr=%h required 3/3", wr_count, ram_addr); end
    vectors++; if (glitches !== 0) begin errors++; $display("FAIL b2b_stable glitches=%0d required 0", glitches); end
  endtask

  task automatic test_wrap;
    int w0;
    addr_load = 1'b1;
    addr_in   = 4'hD;
    #1;
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL wrap_ready_load got=%b required 0", in_ready); end
    tick();
    addr_load = 1'b0;
    vectors++; if (ram_addr !== 4'hD || wr_count !== 5'd0) begin errors++; $display("FAIL wrap_load addr=%h cnt=%0d required d/0", ram_addr, wr_count); end
    send_byte(8'hA1);
    wait_idle("wrap1");
    send_byte(8'hA2);
    wait_idle("wrap2");
    send_byte(8'hA3);
    wait_idle("wrap3");
    vectors++; if (done !== 1'b1 || ram_addr !== 4'h0) begin errors++; $display("FAIL wrap_done done=%b addr=%h required 1/0", done, ram_addr); end
    vectors++; if (wr_count !== 5'd3) begin errors++; $display("FAIL wrap_count got=%0d required 3", wr_count); end
    vectors++; if (mem[13] !== 8'hA1 || mem[14] !== 8'hA2 || mem[15] !== 8'hA3) begin errors++; $display("FAIL wrap_mem got=%h %h %h required a1 a2 a3", mem[13], mem[14], mem[15]); end
    w0 = nwrites;
    in_data  = 8'hA4;
    in_valid = 1'b1;
    tick(); tick(); tick();
    vectors++; if (in_ready !== 1'b0 || busy !== 1'b0 || nwrites !== w0) begin errors++; $display("FAIL wrap_refuse ready=%b busy=%b writes=%0d required 0/0/%0d", in_ready, busy, nwrites, w0); end
    $display("byte a4 pending while done cycle %0d", cyc);
  endtask

  task automatic test_done_clear;
    addr_load = 1'b1;
    addr_in   = 4'h0;
    #1;
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_ready_load got=%b required 0", in_ready); end
    tick();
    addr_load = 1'b0;
    #1;
    vectors++; if (done !== 1'b0 || wr_count !== 5'd0 || ram_addr !== 4'h0) begin errors++; $display("FAIL clr_state done=%b cnt=%0d addr=%h required 0/0/0", done, wr_count, ram_addr); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clr_ready got=%b required 1", in_ready); end
    $display("tx byte a4 at addr %h cycle %0d", ram_addr, cyc);
    tick();
    in_valid = 1'b0;
    wait_idle("clr");
    vectors++; if (mem[0] !== 8'hA4 || wr_count !== 5'd1 || ram_addr !== 4'h1) begin errors++; $display("FAIL clr_write mem0=%h cnt=%0d addr=%h required a4/1/1", mem[0], wr_count, ram_addr); end
  endtask

  task automatic test_abort;
    int w0;
    w0 = nwrites;
    send_byte(8'h5A);
    tick();
    vectors++; if (nWE !== 1'b0 || CS !== 1'b1 || ram_data !== 8'h5A) begin errors++; $display("FAIL abort_strobe nWE=%b CS=%b data=%h required 0/1/5a", nWE, CS, ram_data); end
    run = 1'b1;
    #1;
    vectors++; if (nWE !== 1'b1 || CS !== 1'b0 || ram_data !== 8'h00) begin errors++; $display("FAIL abort_hiz nWE=%b CS=%b data=%h required released", nWE, CS, ram_data); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b required 0", in_ready); end
    tick();
    vectors++; if (busy !== 1'b0 || ram_addr !== 4'h1 || wr_count !== 5'd1) begin errors++; $display("FAIL abort_state busy=%b addr=%h cnt=%0d required 0/1/1", busy, ram_addr, wr_count); end
    tick();
    vectors++; if (mem[1] !== 8'h2F || nwrites !== w0) begin errors++; $display("FAIL abort_mem mem1=%h writes=%0d required 2f/%0d", mem[1], nwrites, w0); end
    run = 1'b0;
    #1;
    vectors++; if (CS !== 1'b0 || nWE !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_resume CS=%b nWE=%b ready=%b required 0/1/1", CS, nWE, in_ready); end
    $display("write of 5a aborted cycle %0d", cyc);
  endtask

  task automatic test_async_reset;
    send_byte(8'h77);
    tick();
    vectors++; if (nWE !== 1'b0) begin errors++; $display("FAIL arst_strobe nWE=%b required 0", nWE); end
    #2;
    nCLR = 1'b0;
    #1;
    vectors++; if (nWE !== 1'b1 || CS !== 1'b0) begin errors++; $display("FAIL arst_pins nWE=%b CS=%b required 1/0", nWE, CS); end
    vectors++; if (ram_addr !== 4'h0 || busy !== 1'b0 || wr_count !== 5'd0 || done !== 1'b0) begin errors++; $display("FAIL arst_state addr=%h busy=%b cnt=%0d done=%b required 0/0/0/0", ram_addr, busy, wr_count, done); end
    #1;
    nCLR = 1'b1;
    tick();
    $display("async reset applied mid-strobe cycle %0d", cyc);
  endtask

  task automatic test_load_priority;
    addr_load = 1'b1;
    addr_in   = 4'h9;
    in_data   = 8'hC3;
    in_valid  = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL prio_ready got=%b required 0", in_ready); end
    tick();
    addr_load = 1'b0;
    #1;
    vectors++; if (ram_addr !== 4'h9 || busy !== 1'b0) begin errors++; $display("FAIL prio_load addr=%h busy=%b required 9/0", ram_addr, busy); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL prio_ready_next got=%b required 1", in_ready); end
    $display("tx byte c3 at addr %h cycle %0d", ram_addr, cyc);
    tick();
    in_valid = 1'b0;
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL prio_accept busy=%b required 1", busy); end
    wait_idle("prio");
    vectors++; if (mem[9] !== 8'hC3 || ram_addr !== 4'hA || wr_count !== 5'd1) begin errors++; $display("FAIL prio_write mem9=%h addr=%h cnt=%0d required c3/a/1", mem[9], ram_addr, wr_count); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wrap();
    test_done_clear();
    test_abort();
    test_async_reset();
    test_load_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
